// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-to-dmem path: access codes, store-buffer entry,
// buffer FSM states and the byte-range overlap test.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_RB,
    ACC_RW,
    ACC_WB,
    ACC_WW
  } acc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_word;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD_WAIT,
    LOAD_DONE
  } sb_state_t;

  function automatic acc_t decode_acc(input logic wb, input logic ww,
                                      input logic rb, input logic rw);
    if (wb) return ACC_WB;
    if (ww) return ACC_WW;
    if (rb) return ACC_RB;
    if (rw) return ACC_RW;
    return ACC_NONE;
  endfunction

  // 33-bit range ends so an access near 0xFFFFFFFF never wraps to address 0.
  function automatic logic range_overlap(input logic [31:0] a_lo, input logic a_word,
                                         input logic [31:0] b_lo, input logic b_word);
    logic [32:0] a_hi;
    logic [32:0] b_hi;
    a_hi = {1'b0, a_lo} + (a_word ? 33'd3 : 33'd0);
    b_hi = {1'b0, b_lo} + (b_word ? 33'd3 : 33'd0);
    return ({1'b0, a_lo} <= b_hi) && ({1'b0, b_lo} <= a_hi);
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of store entries; exposes every slot's address, size and
// valid bit so the load overlap check can scan all entries in parallel.
module sb_fifo import cpu_mem_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  sb_entry_t                   wr_entry,
  output sb_entry_t                   head,
  output logic [DEPTH-1:0][31:0]      ent_addr,
  output logic [DEPTH-1:0]            ent_word,
  output logic [DEPTH-1:0]            valid,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  sb_entry_t [DEPTH-1:0] slots;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != FULL);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // A slot is live when its distance from the head is below the fill count.
  always_comb begin
    valid    = '0;
    ent_addr = '0;
    ent_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]    = {1'b0, AW'(i) - rd_ptr} < count;
      ent_addr[i] = slots[i].addr;
      ent_word[i] = slots[i].is_word;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU datapath and dmem: stores are queued and
// drained in idle cycles, loads bypass pending stores unless they overlap one.
//
// state     | meaning
// IDLE      | accept stores, drain when the CPU is not storing, decode loads
// DRAIN     | overlapping load held; drain until empty, then issue the read
// LOAD_WAIT | read command on the mem port, counting down the read latency
// LOAD_DONE | load data registered; stall released for one cycle
module store_buffer import cpu_mem_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            cpu_address,
  input  logic [31:0]            cpu_WriteData,
  input  logic                   cpu_MemWriteB,
  input  logic                   cpu_MemWriteW,
  input  logic                   cpu_MemReadB,
  input  logic                   cpu_MemReadW,
  output logic [31:0]            cpu_ReadData,
  output logic                   cpu_stall,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_WriteData,
  output logic                   mem_MemWriteB,
  output logic                   mem_MemWriteW,
  output logic                   mem_MemReadB,
  output logic                   mem_MemReadW,
  input  logic [31:0]            mem_ReadData,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   sb_empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0]    LAT  = 3'(MEM_RD_LAT);

  acc_t                  acc;
  sb_state_t             state;
  sb_entry_t             new_entry;
  sb_entry_t             head;
  logic [DEPTH-1:0][31:0] ent_addr;
  logic [DEPTH-1:0]      ent_word;
  logic [DEPTH-1:0]      valid;
  logic                  is_store;
  logic                  is_load;
  logic                  load_word;
  logic                  full;
  logic                  hit;
  logic                  push;
  logic                  pop;
  logic                  start_read;
  logic [2:0]            wait_cnt;

  assign acc       = decode_acc(cpu_MemWriteB, cpu_MemWriteW, cpu_MemReadB, cpu_MemReadW);
  assign is_store  = (acc == ACC_WB) || (acc == ACC_WW);
  assign is_load   = (acc == ACC_RB) || (acc == ACC_RW);
  assign load_word = (acc == ACC_RW);
  assign full      = (sb_count == FULL);
  assign sb_empty  = (sb_count == '0);
  assign new_entry = '{addr: cpu_address, data: cpu_WriteData, is_word: (acc == ACC_WW)};

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && range_overlap(ent_addr[i], ent_word[i], cpu_address, load_word))
        hit = 1'b1;
  end

  always_comb begin
    case (state)
      IDLE:      cpu_stall = is_load || (is_store && full);
      LOAD_DONE: cpu_stall = 1'b0;
      default:   cpu_stall = 1'b1;
    endcase
  end

  // Drain only in cycles where the CPU is not depositing a store, so a burst
  // of stores fills the buffer and a stalled store waits for exactly one drain.
  assign push       = (state == IDLE) && is_store && !full;
  assign start_read = ((state == IDLE) && is_load && !hit) || ((state == DRAIN) && sb_empty);
  assign pop        = ((state == IDLE) || (state == DRAIN)) && !start_read && !push && !sb_empty;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (new_entry),
    .head     (head),
    .ent_addr (ent_addr),
    .ent_word (ent_word),
    .valid    (valid),
    .count    (sb_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      cpu_ReadData  <= '0;
      mem_address   <= '0;
      mem_WriteData <= '0;
      mem_MemWriteB <= 1'b0;
      mem_MemWriteW <= 1'b0;
      mem_MemReadB  <= 1'b0;
      mem_MemReadW  <= 1'b0;
    end else begin
      mem_MemWriteB <= 1'b0;
      mem_MemWriteW <= 1'b0;
      if (pop) begin
        mem_address   <= head.addr;
        mem_WriteData <= head.is_word ? head.data : {24'h0, head.data[7:0]};
        mem_MemWriteB <= !head.is_word;
        mem_MemWriteW <= head.is_word;
      end
      if (start_read) begin
        mem_address   <= cpu_address;
        mem_WriteData <= '0;
        mem_MemReadB  <= !load_word;
        mem_MemReadW  <= load_word;
        wait_cnt      <= LAT;
        state         <= LOAD_WAIT;
      end else begin
        case (state)
          IDLE:
            if (is_load) state <= DRAIN;
          LOAD_WAIT: begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
              cpu_ReadData <= mem_ReadData;
              mem_MemReadB <= 1'b0;
              mem_MemReadW <= 1'b0;
              state        <= LOAD_DONE;
            end
          end
          LOAD_DONE:
            state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// against a transaction-level model (pending-store queue and byte-wide dmem).
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int K_NONE = 0, K_RB = 1, K_RW = 2, K_WB = 3, K_WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] cpu_address = '0, cpu_WriteData = '0;
  logic cpu_MemWriteB = 1'b0, cpu_MemWriteW = 1'b0, cpu_MemReadB = 1'b0, cpu_MemReadW = 1'b0;
  logic [31:0] cpu_ReadData, mem_address, mem_WriteData;
  logic [31:0] mem_ReadData = '0;
  logic cpu_stall, mem_MemWriteB, mem_MemWriteW, mem_MemReadB, mem_MemReadW, sb_empty;
  logic [$clog2(DEPTH):0] sb_count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_address(cpu_address), .cpu_WriteData(cpu_WriteData),
    .cpu_MemWriteB(cpu_MemWriteB), .cpu_MemWriteW(cpu_MemWriteW),
    .cpu_MemReadB(cpu_MemReadB), .cpu_MemReadW(cpu_MemReadW),
    .cpu_ReadData(cpu_ReadData), .cpu_stall(cpu_stall),
    .mem_address(mem_address), .mem_WriteData(mem_WriteData),
    .mem_MemWriteB(mem_MemWriteB), .mem_MemWriteW(mem_MemWriteW),
    .mem_MemReadB(mem_MemReadB), .mem_MemReadW(mem_MemReadW),
    .mem_ReadData(mem_ReadData), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit [31:0] addr; bit [31:0] data; bit word; } st_t;
  st_t q[$];
  bit [7:0] dmem [bit [31:0]];
  bit in_load = 0, load_word = 0, load_ovl = 0, exp_wr_next = 0;
  bit [31:0] load_addr = 0;
  int load_age = 0, load_len = 0, rd_age = 0, max_count = 0;

  function automatic int req_kind();
    if (cpu_MemWriteB) return K_WB;
    if (cpu_MemWriteW) return K_WW;
    if (cpu_MemReadB)  return K_RB;
    if (cpu_MemReadW)  return K_RW;
    return K_NONE;
  endfunction

  function automatic bit overlaps(input bit [31:0] a, input bit aw, input bit [31:0] b, input bit bw);
    longint alo = a, ahi = longint'(a) + (aw ? 3 : 0);
    longint blo = b, bhi = longint'(b) + (bw ? 3 : 0);
    return (alo <= bhi) && (blo <= ahi);
  endfunction

  // Architectural byte: dmem contents with pending stores applied in order.
  function automatic bit [7:0] arch_byte(input bit [31:0] a, input bit with_pending);
    bit [7:0] b = dmem.exists(a) ? dmem[a] : 8'h00;
    if (with_pending)
      foreach (q[i]) begin
        if (q[i].word && a >= q[i].addr && longint'(a) <= longint'(q[i].addr) + 3)
          b = q[i].data[8*(a - q[i].addr) +: 8];
        else if (!q[i].word && a == q[i].addr)
          b = q[i].data[7:0];
      end
    return b;
  endfunction

  function automatic bit [31:0] load_val(input bit [31:0] a, input bit word, input bit with_pending);
    bit [7:0] b0 = arch_byte(a, with_pending);
    if (word)
      return {arch_byte(a + 3, with_pending), arch_byte(a + 2, with_pending),
              arch_byte(a + 1, with_pending), b0};
    return {{24{b0[7]}}, b0};
  endfunction

  // Compare process: one pass per cycle, mid-cycle.
  always @(negedge clk) begin
    int kind;
    bit wr, rd, exp_stall, exp_rd, drain_ok, accept, ovl;
    if (!rst_n) begin
      q.delete();
      in_load = 0;
      exp_wr_next = 0;
      rd_age = 0;
      mem_ReadData = '0;
    end else begin
      wr = mem_MemWriteB | mem_MemWriteW;
      rd = mem_MemReadB | mem_MemReadW;
      check("mem_write_pulse", {31'b0, wr}, {31'b0, exp_wr_next});
      if (wr) begin
        if (q.size() > 0) begin
          check("wr_addr", mem_address, q[0].addr);
          check("wr_is_word", {31'b0, mem_MemWriteW}, {31'b0, q[0].word});
          check("wr_data", mem_WriteData, q[0].word ? q[0].data : {24'h0, q[0].data[7:0]});
          void'(q.pop_front());
        end
        if (mem_MemWriteW)
          for (int k = 0; k < 4; k++) dmem[mem_address + k] = mem_WriteData[8*k +: 8];
        else
          dmem[mem_address] = mem_WriteData[7:0];
      end
      check("sb_count", {29'b0, sb_count}, q.size());
      check("sb_empty", {31'b0, sb_empty}, {31'b0, q.size() == 0});
      if (int'(sb_count) > max_count) max_count = int'(sb_count);

      kind = req_kind();
      exp_stall = 0; drain_ok = 0; accept = 0;
      if (kind == K_WB || kind == K_WW) begin
        exp_stall = (q.size() == DEPTH);
        drain_ok  = exp_stall;
        accept    = !exp_stall;
      end else if (kind == K_RB || kind == K_RW) begin
        if (!in_load) begin
          in_load = 1; load_age = 0; load_addr = cpu_address; load_word = (kind == K_RW);
          ovl = 0;
          foreach (q[i]) if (overlaps(q[i].addr, q[i].word, load_addr, load_word)) ovl = 1;
          load_ovl = ovl;
          load_len = (ovl ? q.size() : 0) + LAT + 1;
        end
        exp_stall = (load_age < load_len);
        drain_ok  = load_ovl && exp_stall;
      end else begin
        drain_ok = 1;
      end
      check("cpu_stall", {31'b0, cpu_stall}, {31'b0, exp_stall});

      exp_rd = in_load && (load_age >= load_len - LAT) && (load_age < load_len);
      check("mem_read", {31'b0, rd}, {31'b0, exp_rd});
      if (rd && exp_rd) begin
        check("rd_addr", mem_address, load_addr);
        check("rd_is_word", {31'b0, mem_MemReadW}, {31'b0, load_word});
      end
      if (in_load && !exp_stall) begin
        check("load_data", cpu_ReadData, load_val(load_addr, load_word, 1'b1));
        in_load = 0;
      end else if (in_load) begin
        load_age++;
      end

      exp_wr_next = drain_ok && (q.size() > 0);
      if (accept) q.push_back('{addr: cpu_address, data: cpu_WriteData, word: (kind == K_WW)});

      // dmem model: data valid once the read has been held LAT cycles
      if (rd) rd_age++; else rd_age = 0;
      mem_ReadData = (rd && rd_age >= LAT) ? load_val(mem_address, mem_MemReadW, 1'b0) : 32'hBAD0BAD0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int kind, input bit [31:0] addr, input bit [31:0] data, input bit extra);
    cpu_MemWriteB = (kind == K_WB);
    cpu_MemWriteW = (kind == K_WW) || (extra && kind == K_WB && $urandom_range(0, 1) == 1);
    cpu_MemReadB  = (kind == K_RB) || (extra && (kind == K_WB || kind == K_WW) && $urandom_range(0, 1) == 1);
    cpu_MemReadW  = (kind == K_RW) || (extra && kind != K_RW && kind != K_NONE && $urandom_range(0, 1) == 1);
    cpu_address   = addr;
    cpu_WriteData = data;
  endtask

  task automatic do_req(input int kind, input bit [31:0] addr, input bit [31:0] data,
                        input bit extra, output int stalls);
    bit st;
    stalls = 0;
    set_req(kind, addr, data, extra);
    for (int guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      st = cpu_stall;
      @(posedge clk);
      #1;
      if (!st) return;
      stalls++;
    end
    checks++;
    errors++;
    $display("FAIL req_timeout kind=%0d addr=%h still stalled after 100 cycles", kind, addr);
  endtask

  task automatic idle(input int n);
    int s;
    for (int i = 0; i < n; i++) do_req(K_NONE, 32'h0, 32'h0, 1'b0, s);
  endtask

  initial begin
    int s;
    int kinds;
    dmem[32'h400] = 8'h01;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_mem_addr", mem_address, 32'h0);
    check("reset_mem_wdata", mem_WriteData, 32'h0);
    check("reset_mem_strobes", {28'b0, mem_MemWriteB, mem_MemWriteW, mem_MemReadB, mem_MemReadW}, 32'h0);
    check("reset_cpu_rdata", cpu_ReadData, 32'h0);
    check("reset_count", {29'b0, sb_count}, 32'h0);
    @(posedge clk); #1;

    // three back-to-back word stores
    max_count = 0;
    do_req(K_WW, 32'h100, 32'h11111111, 1'b0, s); check("st1_stall", s, 0);
    do_req(K_WW, 32'h104, 32'h22222222, 1'b0, s); check("st2_stall", s, 0);
    do_req(K_WW, 32'h108, 32'h33333333, 1'b0, s); check("st3_stall", s, 0);
    idle(6);
    check("peak_count_3", max_count, 3);
    check("empty_after_drain", {31'b0, sb_empty}, 32'h1);
    check("dmem_0x104", {dmem[32'h107], dmem[32'h106], dmem[32'h105], dmem[32'h104]}, 32'h22222222);

    // five stores into a 4-deep buffer: the fifth waits for one drain
    for (int i = 0; i < 5; i++) begin
      do_req(K_WW, 32'h140 + 4 * i, 32'hA0000000 + i, 1'b0, s);
      check("burst_stall", s, (i == 4) ? 1 : 0);
    end
    idle(8);
    check("dmem_0x150", {dmem[32'h153], dmem[32'h152], dmem[32'h151], dmem[32'h150]}, 32'hA0000004);

    // overlapping byte load drains first
    do_req(K_WW, 32'h200, 32'hDEADBEEF, 1'b0, s);
    do_req(K_RB, 32'h202, 32'h0, 1'b0, s);
    check("ovl_stall_cycles", s, 3);
    check("ovl_read_data", cpu_ReadData, 32'hFFFFFFAD);
    idle(3);

    // non-overlapping load bypasses the pending store
    do_req(K_WW, 32'h300, 32'h55667788, 1'b0, s);
    do_req(K_RW, 32'h400, 32'h0, 1'b0, s);
    check("bypass_stall_cycles", s, 2);
    check("bypass_read_data", cpu_ReadData, 32'h00000001);
    check("bypass_store_pending", {29'b0, sb_count}, 32'h1);
    idle(3);

    // misaligned word store overlapping a byte load
    do_req(K_WW, 32'h1FE, 32'hA1B2C3D4, 1'b0, s);
    do_req(K_RB, 32'h201, 32'h0, 1'b0, s);
    check("misaligned_stall_cycles", s, 3);
    check("misaligned_read_data", cpu_ReadData, 32'hFFFFFFA1);
    idle(3);

    // reset while a load waits with two stores buffered
    do_req(K_WW, 32'h500, 32'h12345678, 1'b0, s);
    do_req(K_WW, 32'h504, 32'h9ABCDEF0, 1'b0, s);
    set_req(K_RW, 32'h600, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_count", {29'b0, sb_count}, 32'h2);
    check("pre_reset_read_cmd", {31'b0, mem_MemReadW}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(K_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_strobes", {28'b0, mem_MemWriteB, mem_MemWriteW, mem_MemReadB, mem_MemReadW}, 32'h0);
    check("rst_cpu_rdata", cpu_ReadData, 32'h0);
    check("rst_count", {29'b0, sb_count}, 32'h0);
    @(posedge clk); #1;
    idle(4);
    check("rst_no_write_0x500", {24'b0, dmem[32'h500]}, 32'h0);

    // random traffic in a small window so overlaps and full buffers are common
    for (int n = 0; n < 400; n++) begin
      kinds = $urandom_range(0, 9);
      if (kinds < 2)
        do_req(K_NONE, 32'h0, 32'h0, 1'b0, s);
      else if (kinds < 6)
        do_req(($urandom_range(0, 1) == 1) ? K_WW : K_WB, 32'h800 + $urandom_range(0, 23),
               $urandom, $urandom_range(0, 1) == 1, s);
      else
        do_req(($urandom_range(0, 1) == 1) ? K_RW : K_RB, 32'h800 + $urandom_range(0, 23),
               $urandom, $urandom_range(0, 1) == 1, s);
    end
    idle(8);
    check("final_empty", {31'b0, sb_empty}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle CPU datapath and dmem.
- Accepts byte and word stores from the CPU without stalling while space remains, then drains them to dmem in the background, one per idle cycle.
- Loads go to dmem ahead of pending stores unless they overlap a buffered store. An overlapping load stalls until the buffer has drained.
- Returns load data to the CPU and drives a stall line to freeze the PC.

Parameters:
- DEPTH, 4, number of store entries (power of two, 2..16).
- MEM_RD_LAT, 1, cycles from the first cycle a read command is presented to dmem until mem_ReadData is valid (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- cpu_address  input  32  byte address of the CPU access.
- cpu_WriteData  input  32  store data; a byte store uses [7:0].
- cpu_MemWriteB / cpu_MemWriteW / cpu_MemReadB / cpu_MemReadW  input  1 each  access type.
- cpu_ReadData  output  32  load result, registered.
- cpu_stall  output  1  combinational; while 1, the CPU holds its request stable.
- mem_address  output  32  registered dmem address.
- mem_WriteData  output  32  registered dmem store data.
- mem_MemWriteB / mem_MemWriteW / mem_MemReadB / mem_MemReadW  output  1 each  registered dmem command.
- mem_ReadData  input  32  dmem read data, already sign-extended for byte reads.
- sb_count  output  $clog2(DEPTH)+1  number of valid entries.
- sb_empty  output  1  sb_count==0.

Behaviour:
- Reset (rst_n==0 at posedge):
  - FIFO pointers cleared and sb_count=0; pending stores are discarded.
  - All mem_* outputs = 0, cpu_ReadData = 0, state = IDLE.
  - Reset during a load aborts it; no write is issued.
- Request decode: priority WriteB > WriteW > ReadB > ReadW. Lower-priority strobes are ignored when several are high.
- Entry contents: {addr[31:0], data[31:0], is_word}.
  - Store byte range is [addr, addr+0] for a byte, [addr, addr+3] for a word.
  - Ranges use 33-bit unsigned ends, so there is no wrap-around.
- Stores:
  - cpu_stall = (sb_count==DEPTH).
  - Enqueue at a posedge where a store is requested and cpu_stall==0.
  - A full buffer does not accept a store in the same cycle as a dequeue. It stalls one cycle.
- Load overlap test: the load range is compared against every valid entry.
  - Overlap exists if load_lo<=st_hi and st_lo<=load_hi.
- FSM states: IDLE, DRAIN, LOAD_WAIT, LOAD_DONE.
  - IDLE, load with overlap: cpu_stall=1, go to DRAIN.
  - IDLE, load without overlap: cpu_stall=1. Register the mem read command, load the wait counter with MEM_RD_LAT, go to LOAD_WAIT.
  - DRAIN: cpu_stall=1. When sb_empty is seen at a posedge, issue the read and go to LOAD_WAIT.
  - LOAD_WAIT: read command held and counter decrements each cycle.
    - On the posedge where the counter reaches 0, capture mem_ReadData into cpu_ReadData and go to LOAD_DONE.
  - LOAD_DONE: cpu_stall=0 for exactly one cycle, so the CPU retires the load. Return to IDLE.
  - Total stall for a non-overlapping load = MEM_RD_LAT+1 cycles.
- Drain:
  - Allowed in any state where the mem port is not carrying a read: IDLE or DRAIN, and the next state is not LOAD_WAIT.
  - If the buffer is not empty, the head entry is presented as a one-cycle mem write pulse (MemWriteB or MemWriteW by is_word). The head is dequeued at that edge.
  - The mem port idles to all-zero strobes otherwise. At most one write per cycle; stores drain in FIFO order.
- Simultaneous events:
  - An enqueue and a dequeue in the same cycle leave sb_count unchanged.
  - A store accepted in the same cycle as a drain enters at the tail and never bypasses the head.
- Data width: byte stores write WriteData[7:0] to mem_WriteData[7:0], with the upper bits zero. Sign extension is dmem's responsibility.

Decomposition:
- Shared package cpu_mem_pkg:
  - access-type encoding (ACC_NONE, ACC_RB, ACC_RW, ACC_WB, ACC_WW);
  - the store-entry struct;
  - FSM state enum;
  - a range_overlap function.
- Sub-module: sb_fifo, a parameterised circular FIFO with per-entry valid outputs for the parallel overlap check.

Test Plan:
- Reset, then 3 word stores (0x100←0x11111111, 0x104←0x22222222, 0x108←0x33333333) on back-to-back cycles -> no stall; sb_count peaks at 3; three mem writes in order; sb_empty afterwards.
- DEPTH=4: 5 back-to-back stores with no idle cycles -> cpu_stall=1 on the 5th; it is accepted after one drain; 5 writes in order.
- Store word 0x200←0xDEADBEEF, then immediately ReadB 0x202 -> DRAIN state; read issued only after the write; cpu_ReadData=0xFFFFFFAD.
- Buffered store to 0x300, ReadW 0x400 (mem holds 0x00000001) -> load issued before the drain; stall 2 cycles (MEM_RD_LAT=1); cpu_ReadData=0x00000001.
- Word store to 0x1FE (misaligned), ReadB 0x201 -> overlap detected (0x201 within 0x1FE..0x201); drain first.
- rst_n=0 in LOAD_WAIT with 2 stores buffered -> next cycle all outputs 0, sb_count=0, no mem write issued.
